// File: rtl/mult_arb.sv
// mult_arb: two-requester round-robin front end for a shared 4x4 shift-add
// multiplier. It accepts one operand pair at a time, holds the operands on
// m_a/m_b, pulses m_init, waits for m_done and hands the product back to the
// requester that owns the operation. A watchdog turns a hung operation into
// an error result so a dead multiplier can never wedge the requesters.
module mult_arb #(
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,

  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,

  output logic       res0_valid,
  output logic [7:0] res0_pp,
  output logic       res0_err,

  output logic       res1_valid,
  output logic [7:0] res1_pp,
  output logic       res1_err,

  output logic       m_init,
  output logic [3:0] m_a,
  output logic [3:0] m_b,
  input  logic       m_done,
  input  logic [7:0] m_pp,

  output logic       busy
);

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESULT,
    S_RELEASE,
    S_ABORT
  } state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       owner_q, owner_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] timer_q, timer_d;

  logic       res0_valid_q, res0_valid_d;
  logic [7:0] res0_pp_q, res0_pp_d;
  logic       res0_err_q, res0_err_d;
  logic       res1_valid_q, res1_valid_d;
  logic [7:0] res1_pp_q, res1_pp_d;
  logic       res1_err_q, res1_err_d;

  logic       grant0, grant1;
  logic       accept;
  logic [7:0] timer_inc;
  logic       timeout_hit;
  logic       post_result;
  logic [7:0] post_pp;
  logic       post_err;

  // Round-robin pick in IDLE; a lingering m_done from the last operation blocks everyone.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE && !m_done) begin
      if (req0_valid && req1_valid) begin
        if (last_grant_q) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept = grant0 | grant1;

  // Watchdog arithmetic: abort once the count would reach TIMEOUT, saturating at 255.
  always_comb begin
    timer_inc   = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    timeout_hit = (timer_inc >= TIMEOUT_V);
  end

  // Sequencer next state, operand capture, timer and the result to post this cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    timer_d      = timer_q;
    post_result  = 1'b0;
    post_pp      = 8'd0;
    post_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          a_d          = grant1 ? req1_a : req0_a;
          b_d          = grant1 ? req1_b : req0_b;
          state_d      = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        timer_d = 8'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        timer_d = timer_inc;
        if (m_done) begin
          post_result = 1'b1;
          post_pp     = m_pp;
          state_d     = S_RESULT;
        end else if (timeout_hit) begin
          post_result = 1'b1;
          post_err    = 1'b1;
          state_d     = S_ABORT;
        end
      end

      S_RESULT: begin
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        if (!m_done) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_inc;
          if (timeout_hit) begin
            post_result = 1'b1;
            post_err    = 1'b1;
            state_d     = S_ABORT;
          end
        end
      end

      S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Steer the posted result to the owner only; everything else is zero so outputs pulse cleanly.
  always_comb begin
    res0_valid_d = 1'b0;
    res0_pp_d    = 8'd0;
    res0_err_d   = 1'b0;
    res1_valid_d = 1'b0;
    res1_pp_d    = 8'd0;
    res1_err_d   = 1'b0;
    if (post_result) begin
      if (owner_q) begin
        res1_valid_d = 1'b1;
        res1_pp_d    = post_pp;
        res1_err_d   = post_err;
      end else begin
        res0_valid_d = 1'b1;
        res0_pp_d    = post_pp;
        res0_err_d   = post_err;
      end
    end
  end

  // Control state: FSM, arbitration history, owner and watchdog timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      timer_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      timer_q      <= timer_d;
    end
  end

  // Operand latches: held until the next accept, never cleared on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= 4'd0;
      b_q <= 4'd0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Registered result outputs for both requesters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res0_valid_q <= 1'b0;
      res0_pp_q    <= 8'd0;
      res0_err_q   <= 1'b0;
      res1_valid_q <= 1'b0;
      res1_pp_q    <= 8'd0;
      res1_err_q   <= 1'b0;
    end else begin
      res0_valid_q <= res0_valid_d;
      res0_pp_q    <= res0_pp_d;
      res0_err_q   <= res0_err_d;
      res1_valid_q <= res1_valid_d;
      res1_pp_q    <= res1_pp_d;
      res1_err_q   <= res1_err_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res0_valid = res0_valid_q;
  assign res0_pp    = res0_pp_q;
  assign res0_err   = res0_err_q;
  assign res1_valid = res1_valid_q;
  assign res1_pp    = res1_pp_q;
  assign res1_err   = res1_err_q;
  assign m_init     = (state_q == S_LAUNCH);
  assign m_a        = a_q;
  assign m_b        = b_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: scoreboard bench for mult_arb. A behavioural multiplier model
// answers m_init after a programmable latency (or hangs, or holds done high);
// every accepted operand pair pushes its expected owner, product, error flag
// and arrival cycle, and every result pulse pops and compares one entry.
module tb_mult_arb;
   localparam int TIMEOUT = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0_valid = 1'b0;
   logic [3:0] req0_a = 4'd0;
   logic [3:0] req0_b = 4'd0;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [3:0] req1_a = 4'd0;
   logic [3:0] req1_b = 4'd0;
   logic       req1_ready;
   logic       res0_valid;
   logic [7:0] res0_pp;
   logic       res0_err;
   logic       res1_valid;
   logic [7:0] res1_pp;
   logic       res1_err;
   logic       m_init;
   logic [3:0] m_a;
   logic [3:0] m_b;
   logic       m_done = 1'b0;
   logic [7:0] m_pp = 8'd0;
   logic       busy;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
   } op_t;

   typedef struct {
      int         owner;
      logic [7:0] pp;
      logic       err;
      int         cyc;
   } exp_t;

   op_t  ops0[$];
   op_t  ops1[$];
   exp_t sb[$];
   int   grants[$];

   int         mult_mode = 0;
   int         mult_lat = 3;
   int         mult_hold = 2;
   int         age = -1;
   logic       force_done = 1'b0;
   logic [7:0] prod = 8'd0;

   int         model_last = 1;
   int         last_accept_cyc = -10;
   logic [3:0] exp_a = 4'd0;
   logic [3:0] exp_b = 4'd0;
   int         cyc = 0;
   int         error_count = 0;
   int         check_count = 0;

   mult_arb #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .res0_valid(res0_valid), .res0_pp(res0_pp), .res0_err(res0_err),
      .res1_valid(res1_valid), .res1_pp(res1_pp), .res1_err(res1_err),
      .m_init(m_init), .m_a(m_a), .m_b(m_b), .m_done(m_done), .m_pp(m_pp),
      .busy(busy)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Multiplier stand-in: mode 0 answers init after mult_lat cycles and holds done for
   // mult_hold cycles, mode 1 never answers, mode 2 drives done straight from force_done.
   always @(negedge clk) begin
      if (mult_mode == 0) begin
         if (m_init) begin
            age = 0;
            prod = {4'd0, m_a} * {4'd0, m_b};
         end else if (age >= 0) begin
            age = age + 1;
         end
         if (age >= mult_lat && age < mult_lat + mult_hold) begin
            m_done = 1'b1;
            m_pp = prod;
         end else begin
            m_done = 1'b0;
            m_pp = 8'd0;
         end
         if (age >= mult_lat + mult_hold) age = -1;
      end else if (mult_mode == 1) begin
         m_done = 1'b0;
         m_pp = 8'd0;
      end else begin
         m_done = force_done;
         m_pp = 8'd0;
      end
   end

   // Hard stop in case something upstream never lets the run finish.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", check_count);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic pushOp(input int r, input logic [3:0] a, input logic [3:0] b);
      op_t o;
      o.a = a;
      o.b = b;
      if (r == 0) ops0.push_back(o);
      else ops1.push_back(o);
   endtask

   task automatic applyStimulus();
      req0_valid = (ops0.size() != 0);
      if (ops0.size() != 0) begin
         req0_a = ops0[0].a;
         req0_b = ops0[0].b;
      end
      req1_valid = (ops1.size() != 0);
      if (ops1.size() != 0) begin
         req1_a = ops1[0].a;
         req1_b = ops1[0].b;
      end
   endtask

   task automatic observe();
      exp_t       e;
      int         w;
      logic [7:0] got_pp;
      logic       got_err;
      checkOutput("ready_excl", req0_ready & req1_ready, 0);
      checkOutput("ready_busy", (req0_ready | req1_ready) & busy, 0);
      checkOutput("m_init", m_init, (cyc == last_accept_cyc + 1) ? 1 : 0);
      if (cyc == last_accept_cyc + 1) begin
         checkOutput("m_a", m_a, exp_a);
         checkOutput("m_b", m_b, exp_b);
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
         if (req0_valid && req1_valid) w = (model_last == 0) ? 1 : 0;
         else w = req0_valid ? 0 : 1;
         checkOutput("grant", (req1_valid && req1_ready) ? 1 : 0, w);
         if (w == 0) begin
            exp_a = ops0[0].a;
            exp_b = ops0[0].b;
         end else begin
            exp_a = ops1[0].a;
            exp_b = ops1[0].b;
         end
         e.owner = w;
         e.err = (mult_mode == 1);
         e.pp = e.err ? 8'd0 : ({4'd0, exp_a} * {4'd0, exp_b});
         e.cyc = cyc + (e.err ? TIMEOUT + 2 : mult_lat + 2);
         sb.push_back(e);
         model_last = w;
         last_accept_cyc = cyc;
         grants.push_back(w);
         if (req0_valid && req0_ready) void'(ops0.pop_front());
         else void'(ops1.pop_front());
      end
      if (res0_valid || res1_valid) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_result", 1, 0);
         end else begin
            e = sb.pop_front();
            got_pp = res1_valid ? res1_pp : res0_pp;
            got_err = res1_valid ? res1_err : res0_err;
            checkOutput("res_both", res0_valid & res1_valid, 0);
            checkOutput("res_owner", res1_valid ? 1 : 0, e.owner);
            checkOutput("res_pp", got_pp, e.pp);
            checkOutput("res_err", got_err, e.err);
            checkOutput("res_cycle", cyc, e.cyc);
         end
      end
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
         checkOutput("res_missing", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (!res0_valid) checkOutput("res0_quiet", {res0_err, res0_pp}, 0);
      if (!res1_valid) checkOutput("res1_quiet", {res1_err, res1_pp}, 0);
   endtask

   task automatic cycle();
      @(negedge clk);
      cyc++;
      applyStimulus();
      #1;
      observe();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || ops0.size() != 0 || ops1.size() != 0 || busy) && n < budget) begin
         cycle();
         n++;
      end
      if (n >= budget) checkOutput("drain_timeout", 1, 0);
   endtask

   // Called at negedge+1: asserts reset, checks the asynchronous clear, holds two cycles.
   task automatic doReset();
      rst = 1'b0;
      sb.delete();
      ops0.delete();
      ops1.delete();
      model_last = 1;
      last_accept_cyc = -10;
      age = -1;
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_res0_valid", res0_valid, 0);
      checkOutput("rst_res1_valid", res1_valid, 0);
      checkOutput("rst_m_init", m_init, 0);
      checkOutput("rst_m_a", m_a, 0);
      checkOutput("rst_m_b", m_b, 0);
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   // Directed scenarios, each feeding the scoreboard through the requester queues.
   initial begin
      @(negedge clk);
      #1;
      doReset();

      $display("[TB] single request from requester 0: 3 x 5");
      mult_mode = 0;
      mult_lat = 3;
      grants.delete();
      pushOp(0, 4'd3, 4'd5);
      drain(40);
      checkOutput("t1_grants", grants.size(), 1);

      $display("[TB] simultaneous requests after reset: 15 x 15 and 2 x 7");
      doReset();
      grants.delete();
      pushOp(0, 4'd15, 4'd15);
      pushOp(1, 4'd2, 4'd7);
      drain(80);
      checkOutput("t2_grants", grants.size(), 2);
      for (int i = 0; i < grants.size() && i < 2; i++) checkOutput("t2_order", grants[i], i);

      $display("[TB] six back-to-back operations with both requesters valid");
      grants.delete();
      mult_lat = 1;
      pushOp(0, 4'd1, 4'd1);
      pushOp(1, 4'd6, 4'd7);
      pushOp(0, 4'd2, 4'd3);
      pushOp(1, 4'd8, 4'd9);
      pushOp(0, 4'd4, 4'd5);
      pushOp(1, 4'd10, 4'd11);
      drain(200);
      checkOutput("t3_grants", grants.size(), 6);
      for (int i = 0; i < grants.size() && i < 6; i++) checkOutput("t3_alternate", grants[i], i % 2);

      $display("[TB] hung multiplier, watchdog abort");
      mult_lat = 3;
      mult_mode = 1;
      pushOp(0, 4'd9, 4'd9);
      drain(100);
      checkOutput("t4_idle", busy, 0);

      $display("[TB] stale done held high while both requesters wait");
      mult_mode = 2;
      force_done = 1'b1;
      pushOp(0, 4'd1, 4'd2);
      pushOp(1, 4'd3, 4'd4);
      for (int i = 0; i < 5; i++) begin
         cycle();
         checkOutput("stale_ready0", req0_ready, 0);
         checkOutput("stale_ready1", req1_ready, 0);
      end
      force_done = 1'b0;
      mult_mode = 0;
      grants.delete();
      drain(80);
      checkOutput("t5_grants", grants.size(), 2);
      for (int i = 0; i < grants.size() && i < 2; i++) checkOutput("t5_order", grants[i], 1 - i);

      $display("[TB] reset asserted while waiting on the multiplier");
      mult_lat = 6;
      pushOp(0, 4'd6, 4'd7);
      for (int i = 0; i < 10 && sb.size() == 0; i++) cycle();
      checkOutput("t6_accepted", sb.size(), 1);
      cycle();
      cycle();
      cycle();
      doReset();
      mult_lat = 3;
      pushOp(1, 4'd4, 4'd4);
      drain(40);
      for (int i = 0; i < 4; i++) cycle();

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule

// File: doc/mult_arb.md
Name: mult_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one shared 4x4 shift-add multiplier (ports init/A/B/pp/done).
- Accepts operand pairs over a valid/ready handshake and holds A/B stable for the whole operation.
- Pulses `init`, waits for `done`, then returns the 8-bit product to the requester that owns it.
- A watchdog aborts an operation that never completes.

Parameters:
- TIMEOUT, 32, max cycles spent in WAIT plus RELEASE before abort (legal range 4..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  4  requester 0 multiplicand.
- req0_b  in  4  requester 0 multiplier.
- req0_ready  out  1  requester 0 accept; transfer when valid&&ready.
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0.
- res0_valid  out  1  one-cycle result pulse to requester 0.
- res0_pp  out  8  product; valid only when res0_valid=1.
- res0_err  out  1  qualifies res0_valid; 1 = timed out, res0_pp=0.
- res1_valid, res1_pp, res1_err: same as requester 0.
- m_init  out  1  start to multiplier.
- m_a  out  4  multiplier A operand.
- m_b  out  4  multiplier B operand.
- m_done  in  1  multiplier done.
- m_pp  in  8  multiplier product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=1 (so requester 0 wins the first tie), all outputs 0, operand latches 0, timer 0.
- States and transitions:
  - IDLE -> LAUNCH on accept.
  - LAUNCH -> WAIT unconditionally.
  - WAIT -> RESULT when m_done=1 is sampled.
  - RESULT -> RELEASE unconditionally.
  - RELEASE -> IDLE when m_done=0 is sampled.
  - WAIT or RELEASE -> ABORT when the timer reaches TIMEOUT.
  - ABORT -> IDLE.
- IDLE arbitration (combinational ready, registered grant):
  - Ready is eligible only if m_done=0; a stale done blocks acceptance.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester != last_grant gets ready=1; the other stays 0.
  - At most one ready is high in any cycle. Both readys are 0 outside IDLE.
- Accept (cycle T):
  - Latch a/b into m_a/m_b, record owner, last_grant<=owner.
  - m_a/m_b stay constant until the next accept; they are not cleared on completion.
- LAUNCH (T+1): m_init=1 for exactly this cycle; timer cleared.
- WAIT: m_init=0; timer increments each cycle.
- RESULT (cycle after m_done is first sampled high):
  - The owner's res_valid=1 and res_pp=m_pp as sampled in the last WAIT cycle; err=0.
  - The non-owner's result outputs stay 0.
- RELEASE: waits for the multiplier to drop done; timer keeps counting from its WAIT value.
- ABORT (timer==TIMEOUT): owner gets res_valid=1, err=1, pp=0 for one cycle, then IDLE.
  - If the multiplier is still asserting done, the IDLE gate blocks new accepts until it clears.
- Timer: 8-bit, saturating. Cleared in LAUNCH; counts in WAIT and RELEASE.
- Latency with a multiplier done N cycles after init: accept T, init T+1, result pulse T+N+2.
- res_pp is registered: 0 whenever res_valid=0.
- Requester valid dropped mid-operation: no effect; the operation completes and the result still pulses.
- New valid during an operation: ignored until IDLE. After completion the other requester wins any tie.
- Reset mid-operation: immediate return to IDLE, in-flight result discarded, no pulse, m_init=0.

Test Plan:
- req0 a=3 b=5, req1 idle, real multiplier -> req0_ready high one cycle, m_init one-cycle pulse at T+1, res0_valid pulse with res0_pp=15, err=0, res1_valid stays 0.
- req0 (15,15) and req1 (2,7) asserted together and held -> req0 served first with pp=225, then req1 with pp=14; req1_ready never high while busy=1.
- Both requesters continuously valid for 6 operations -> grants strictly alternate 0,1,0,1,0,1.
- Stub multiplier with m_done stuck 0, TIMEOUT=32 -> owner gets res_valid=1, err=1, pp=0 exactly 32 cycles after WAIT entry; state returns to IDLE.
- Stub holds m_done=1 after IDLE entry -> both readys stay 0 until m_done falls, then arbitration resumes.
- rst pulsed low during WAIT -> busy=0 and all res_valid=0 immediately; next requester 1 op (4,4) returns pp=16.
